// File: rtl/core_sequencer_if.sv
// Instruction-fetch handshake between the core sequencer (master) and imem (slave).
// req is held until gnt; rdata is qualified by rvalid.
interface core_sequencer_if #(
   parameter int XLEN = 64
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata
   );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the scalar RV64 core: fetch, decode, exec, writeback.
// Owns the PC, the retired-instruction counter and fault/halt state.
module core_sequencer #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   core_sequencer_if.master    imem,
   output logic [31:0]         instr,
   input  logic                illegal,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [XLEN-1:0]     branch_target,
   output logic                rd_write_en,
   output logic [XLEN-1:0]     pc,
   output logic                retired,
   output logic [63:0]         instret,
   output logic                halted,
   output logic [1:0]          fault
);

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          CW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   localparam logic [1:0] F_NONE     = 2'd0;
   localparam logic [1:0] F_ILLEGAL  = 2'd1;
   localparam logic [1:0] F_TIMEOUT  = 2'd2;
   localparam logic [1:0] F_MISALIGN = 2'd3;

   typedef enum logic [2:0] {
      FETCH_REQ, FETCH_WAIT, DECODE, EXEC, WB, HALT
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   wait_cnt;
   logic [XLEN-1:0] npc;
   logic            timeout_hit;
   logic            misaligned;

   // Counter runs 0..TIMEOUT-1, so TIMEOUT silent cycles in FETCH_WAIT fault.
   assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
   assign misaligned  = branch_taken && (branch_target[1:0] != 2'b00);
   assign imem.imem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH_REQ;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH_REQ:  if (imem.imem_gnt) state_nxt = FETCH_WAIT;
         FETCH_WAIT: begin
            if (imem.imem_rvalid)  state_nxt = DECODE;
            else if (timeout_hit)  state_nxt = HALT;
         end
         DECODE:     state_nxt = illegal ? HALT : EXEC;
         EXEC:       if (!stall) state_nxt = misaligned ? HALT : WB;
         WB:         state_nxt = FETCH_REQ;
         HALT:       state_nxt = HALT;
         default:    state_nxt = FETCH_REQ;
      endcase
   end

   always_comb begin
      imem.imem_req = 1'b0;
      rd_write_en   = 1'b0;
      retired       = 1'b0;
      halted        = 1'b0;
      case (state)
         FETCH_REQ: imem.imem_req = 1'b1;
         WB: begin
            rd_write_en = 1'b1;
            retired     = 1'b1;
         end
         HALT:      halted = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         npc      <= RESET_PC;
         instr    <= NOP;
         instret  <= '0;
         fault    <= F_NONE;
         wait_cnt <= '0;
      end else begin
         case (state)
            FETCH_REQ: wait_cnt <= '0;
            FETCH_WAIT: begin
               // rvalid wins over the timeout on the last allowed cycle.
               if (imem.imem_rvalid)  instr    <= imem.imem_rdata;
               else if (timeout_hit)  fault    <= F_TIMEOUT;
               else                   wait_cnt <= wait_cnt + 1'b1;
            end
            DECODE: if (illegal) fault <= F_ILLEGAL;
            EXEC: begin
               // Branch inputs are only meaningful on the cycle stall drops.
               if (!stall) begin
                  if (misaligned) fault <= F_MISALIGN;
                  npc <= branch_taken ? branch_target : pc + XLEN'(4);
               end
            end
            WB: begin
               pc      <= npc;
               instret <= instret + 64'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: vector table, hand sequences and random
// instructions checked against a per-instruction reference model.
module tb_core_sequencer;

   localparam int          TO   = 8;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [63:0] RPC2 = 64'hFFFF_FFFF_FFFF_FFFC;

   typedef struct {
      int          gnt_dly;
      int          rv_dly;
      int          stall_n;
      logic        taken;
      logic [63:0] target;
      logic        ill;
      logic [31:0] rdata;
      logic [1:0]  exp_fault;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic illegal, stall, branch_taken;
   logic [63:0] branch_target;
   logic [31:0] instr, instr2;
   logic rd_write_en, retired, halted;
   logic rd_write_en2, retired2, halted2;
   logic [63:0] pc, instret, pc2, instret2;
   logic [1:0]  fault, fault2;

   core_sequencer_if #(.XLEN(64)) mif ();
   core_sequencer_if #(.XLEN(64)) mif2 ();

   core_sequencer #(.XLEN(64), .RESET_PC(64'h0), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .imem(mif), .instr(instr), .illegal(illegal),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .rd_write_en(rd_write_en), .pc(pc), .retired(retired), .instret(instret),
      .halted(halted), .fault(fault)
   );

   // Second instance: free-running always-ready memory to exercise PC wrap.
   core_sequencer #(.XLEN(64), .RESET_PC(RPC2), .TIMEOUT(TO)) dut2 (
      .clk(clk), .rst(rst), .imem(mif2), .instr(instr2), .illegal(1'b0),
      .stall(1'b0), .branch_taken(1'b0), .branch_target(64'h0),
      .rd_write_en(rd_write_en2), .pc(pc2), .retired(retired2), .instret(instret2),
      .halted(halted2), .fault(fault2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [63:0] m_pc;
   logic [63:0] m_instret;
   logic [31:0] m_instr;
   logic [1:0]  m_fault;
   logic        m_halt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] ref_fault(input vec_t v);
      if (v.rv_dly >= TO)                       return 2'd2;
      if (v.ill)                                return 2'd1;
      if (v.taken && (v.target[1:0] != 2'b00))  return 2'd3;
      return 2'd0;
   endfunction

   task automatic idle_inputs();
      mif.imem_gnt    = 1'b0;
      mif.imem_rvalid = 1'b0;
      mif.imem_rdata  = 32'h0;
      illegal         = 1'b0;
      stall           = 1'b0;
      branch_taken    = 1'b0;
      branch_target   = 64'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("rst_pc", pc, 64'h0);
      chk("rst_instr", instr, NOP);
      chk("rst_instret", instret, 64'h0);
      chk("rst_fault", fault, 2'd0);
      chk("rst_req", mif.imem_req, 1'b1);
      chk("rst_halted", halted, 1'b0);
      chk("rst_rdwe", rd_write_en, 1'b0);
      chk("rst_retired", retired, 1'b0);
      rst       = 1'b0;
      m_pc      = 64'h0;
      m_instret = 64'h0;
      m_instr   = NOP;
      m_fault   = 2'd0;
      m_halt    = 1'b0;
   endtask

   // Drives one instruction from FETCH_REQ (entered at a negedge) and checks
   // every cycle against the model's view of pc / instr / instret / fault.
   task automatic run_instr(input vec_t v);
      logic [63:0] npc;
      for (int g = 0; g <= v.gnt_dly; g++) begin
         chk("fetch_req", mif.imem_req, 1'b1);
         chk("fetch_addr", mif.imem_addr, m_pc);
         chk("fetch_instr", instr, m_instr);
         mif.imem_gnt    = (g == v.gnt_dly);
         mif.imem_rvalid = (g == v.gnt_dly);   // same-cycle rvalid must be ignored
         mif.imem_rdata  = $urandom;
         @(negedge clk);
      end
      mif.imem_gnt    = 1'b0;
      mif.imem_rvalid = 1'b0;
      if (v.rv_dly >= TO) begin
         for (int w = 0; w < TO; w++) begin
            chk("wait_req", mif.imem_req, 1'b0);
            chk("wait_halted", halted, 1'b0);
            @(negedge clk);
         end
         chk("to_halted", halted, 1'b1);
         chk("to_fault", fault, v.exp_fault);
         chk("to_pc", pc, m_pc);
         m_halt = 1'b1; m_fault = 2'd2;
         return;
      end
      for (int w = 0; w <= v.rv_dly; w++) begin
         chk("wait_req", mif.imem_req, 1'b0);
         chk("wait_instr", instr, m_instr);
         chk("wait_pc", pc, m_pc);
         mif.imem_rvalid = (w == v.rv_dly);
         mif.imem_rdata  = (w == v.rv_dly) ? v.rdata : $urandom;
         @(negedge clk);
      end
      mif.imem_rvalid = 1'b0;
      m_instr = v.rdata;
      chk("dec_instr", instr, m_instr);
      chk("dec_rdwe", rd_write_en, 1'b0);
      illegal       = v.ill;
      branch_taken  = 1'b1;
      branch_target = 64'h102;
      @(negedge clk);
      illegal = 1'b0;
      if (v.ill) begin
         chk("ill_halted", halted, 1'b1);
         chk("ill_fault", fault, v.exp_fault);
         chk("ill_rdwe", rd_write_en, 1'b0);
         chk("ill_instret", instret, m_instret);
         m_halt = 1'b1; m_fault = 2'd1;
         return;
      end
      for (int s = 0; s <= v.stall_n; s++) begin
         chk("exec_instr", instr, m_instr);
         chk("exec_rdwe", rd_write_en, 1'b0);
         chk("exec_pc", pc, m_pc);
         stall = (s < v.stall_n);
         if (s < v.stall_n) begin
            branch_taken  = 1'b1;
            branch_target = (s % 2 == 0) ? 64'h100 : 64'h102;
         end else begin
            branch_taken  = v.taken;
            branch_target = v.target;
         end
         @(negedge clk);
      end
      stall = 1'b0; branch_taken = 1'b0;
      npc = v.taken ? v.target : m_pc + 64'd4;
      if (v.taken && v.target[1:0] != 2'b00) begin
         chk("mis_halted", halted, 1'b1);
         chk("mis_fault", fault, v.exp_fault);
         chk("mis_rdwe", rd_write_en, 1'b0);
         chk("mis_instret", instret, m_instret);
         chk("mis_pc", pc, m_pc);
         m_halt = 1'b1; m_fault = 2'd3;
         return;
      end
      chk("wb_rdwe", rd_write_en, 1'b1);
      chk("wb_retired", retired, 1'b1);
      chk("wb_pc", pc, m_pc);
      chk("wb_instr", instr, m_instr);
      chk("wb_fault", fault, v.exp_fault);
      @(negedge clk);
      m_pc = npc;
      m_instret = m_instret + 64'd1;
      chk("post_rdwe", rd_write_en, 1'b0);
      chk("post_retired", retired, 1'b0);
      chk("post_instret", instret, m_instret);
   endtask

   // HALT must be absorbing whatever the memory and decode inputs do.
   task automatic hold_halt();
      for (int c = 0; c < 20; c++) begin
         mif.imem_gnt    = $urandom % 2;
         mif.imem_rvalid = $urandom % 2;
         illegal         = $urandom % 2;
         chk("halt_req", mif.imem_req, 1'b0);
         chk("halt_halted", halted, 1'b1);
         chk("halt_rdwe", rd_write_en, 1'b0);
         chk("halt_fault", fault, m_fault);
         chk("halt_pc", pc, m_pc);
         @(negedge clk);
      end
      idle_inputs();
   endtask

   vec_t tbl[10];
   vec_t rv;

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{0, 0, 0, 1'b0, 64'h0,   1'b0, ADDI,         2'd0};
      tbl[1] = '{0, 0, 0, 1'b0, 64'h0,   1'b0, ADDI,         2'd0};
      tbl[2] = '{0, 0, 0, 1'b0, 64'h0,   1'b0, ADDI,         2'd0};
      tbl[3] = '{3, 4, 0, 1'b0, 64'h0,   1'b0, 32'h00A00113, 2'd0};
      tbl[4] = '{0, 0, 5, 1'b0, 64'h0,   1'b0, 32'h00208033, 2'd0};
      tbl[5] = '{0, 1, 0, 1'b1, 64'h40,  1'b0, 32'h0000006F, 2'd0};
      tbl[6] = '{0, TO-1, 0, 1'b0, 64'h0, 1'b0, 32'h00300193, 2'd0};
      tbl[7] = '{1, 0, 2, 1'b1, 64'h42,  1'b0, 32'h0000006F, 2'd3};
      tbl[8] = '{0, 0, 0, 1'b0, 64'h0,   1'b1, 32'hFFFFFFFF, 2'd1};
      tbl[9] = '{2, TO, 0, 1'b0, 64'h0,  1'b0, 32'h0,        2'd2};

      do_reset();
      // PC wrap on the always-ready instance: one instruction takes 5 cycles.
      chk("wrap_rst_pc", pc2, RPC2);
      for (int c = 0; c < 5; c++) begin
         chk("idle_req", mif.imem_req, 1'b1);
         @(negedge clk);
      end
      chk("wrap_pc", pc2, 64'h0);
      chk("wrap_instret", instret2, 64'h1);
      chk("idle_pc", pc, 64'h0);

      do_reset();
      for (int i = 0; i < 10; i++) begin
         run_instr(tbl[i]);
         if (i == 2) chk("three_instret", instret, 64'd3);
         if (m_halt) begin
            hold_halt();
            do_reset();
         end
      end

      // Reset during an outstanding fetch, then a stale rvalid.
      mif.imem_gnt = 1'b1;
      @(negedge clk);
      mif.imem_gnt = 1'b0;
      chk("rstw_wait_req", mif.imem_req, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstw_req", mif.imem_req, 1'b1);
      chk("rstw_instr", instr, NOP);
      mif.imem_rvalid = 1'b1;
      mif.imem_rdata  = 32'hDEADBEEF;
      @(negedge clk);
      mif.imem_rvalid = 1'b0;
      chk("stale_req", mif.imem_req, 1'b1);
      @(negedge clk);
      chk("stale_instr", instr, NOP);
      run_instr(tbl[0]);

      for (int n = 0; n < 40; n++) begin
         rv.gnt_dly = $urandom_range(0, 3);
         rv.rv_dly  = ($urandom % 16 == 0) ? TO : $urandom_range(0, 4);
         rv.stall_n = $urandom_range(0, 3);
         rv.taken   = $urandom % 2;
         rv.target  = {$urandom, $urandom};
         rv.target[1:0] = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rv.ill     = ($urandom % 12 == 0);
         rv.rdata   = $urandom;
         rv.exp_fault = ref_fault(rv);
         run_instr(rv);
         if (m_halt) begin
            hold_halt();
            do_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      mif2.imem_gnt    = 1'b1;
      mif2.imem_rvalid = 1'b1;
      mif2.imem_rdata  = NOP;
   end

endmodule
